// File: rtl/fetch_seq_pkg.sv
// Shared CPU definitions used by the fetch stage: reset/handler vectors,
// instruction-memory window and fetch sequencer state encoding.
package fetch_seq_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] IM_LO      = 32'h0000_3000;
   localparam logic [31:0] IM_HI      = 32'h0000_4FFC;
   localparam logic [31:0] PC_STEP    = 32'd4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_addr_chk.sv
// Fetch address checker: flags misaligned or out-of-window instruction addresses.
module fetch_addr_chk
   import fetch_seq_pkg::*;
(
   input  logic [31:0] i_pc,
   output logic        o_adel_f
);

   logic w_misaligned;
   logic w_out_of_range;

   // Word alignment and instruction-memory window check.
   always_comb begin
      w_misaligned   = (i_pc[1:0] != 2'b00);
      w_out_of_range = (i_pc < IM_LO) || (i_pc > IM_HI);
      o_adel_f       = w_misaligned || w_out_of_range;
   end

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage PC sequencer: exception entry/return, branch redirects that
// may be parked while the F stage is stalled, and a one-cycle F/D flush.
module fetch_seq
   import fetch_seq_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        fetch_valid,
   output logic        flush_fd,
   output logic        adel_f,
   output logic        busy
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_pend;
   logic [31:0] w_pend_nxt;
   logic        w_adel;

   fetch_addr_chk u_addr_chk (
      .i_pc     (r_pc),
      .o_adel_f (w_adel)
   );

   // State, pc and pending-target registers; clr overrides every event.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_pend  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Next-pc priority: exception > eret > redirect > stall > pending/sequential.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_nxt  = r_pend;
      if (exc_req) begin
         w_pc_nxt    = HANDLER_PC;
         w_pend_nxt  = '0;
         w_state_nxt = FLUSH;
      end else if (eret) begin
         w_pc_nxt    = epc;
         w_pend_nxt  = '0;
         w_state_nxt = FLUSH;
      end else if (redirect) begin
         // A stalled redirect parks its target; in HOLD the latest one wins.
         if (stall) begin
            w_pend_nxt  = redirect_pc;
            w_state_nxt = HOLD;
         end else begin
            w_pc_nxt    = redirect_pc;
            w_pend_nxt  = '0;
            w_state_nxt = RUN;
         end
      end else if (stall) begin
         w_state_nxt = (r_state == HOLD) ? HOLD : RUN;
      end else if (r_state == HOLD) begin
         w_pc_nxt    = r_pend;
         w_pend_nxt  = '0;
         w_state_nxt = RUN;
      end else begin
         w_pc_nxt    = r_pc + PC_STEP;
         w_state_nxt = RUN;
      end
   end

   // Registered-state-derived outputs.
   always_comb begin
      pc          = r_pc;
      pc4         = r_pc + PC_STEP;
      adel_f      = w_adel;
      flush_fd    = (r_state == FLUSH);
      fetch_valid = !w_adel && (r_state != FLUSH);
      busy        = (r_state == HOLD);
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: directed vector table plus randomized run
// against a behavioural reference model.
module tb_fetch_seq;

   logic        clk;
   logic        clr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fetch_valid;
   logic        flush_fd;
   logic        adel_f;
   logic        busy;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   fetch_seq dut (
      .clk         (clk),
      .clr         (clr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .exc_req     (exc_req),
      .eret        (eret),
      .epc         (epc),
      .pc          (pc),
      .pc4         (pc4),
      .fetch_valid (fetch_valid),
      .flush_fd    (flush_fd),
      .adel_f      (adel_f),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        stall;
      logic        rd;
      logic [31:0] rpc;
      logic        exc;
      logic        er;
      logic [31:0] epc;
      logic [31:0] e_pc;
      logic        e_busy;
      logic        e_flush;
      logic        e_adel;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic s, input logic r,
                               input logic [31:0] rp, input logic x, input logic e,
                               input logic [31:0] ep, input logic [31:0] p,
                               input logic b, input logic f, input logic a);
      vec_t v;
      v.clr = c; v.stall = s; v.rd = r; v.rpc = rp; v.exc = x; v.er = e; v.epc = ep;
      v.e_pc = p; v.e_busy = b; v.e_flush = f; v.e_adel = a;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic s, input logic r, input logic [31:0] rp,
                        input logic x, input logic e, input logic [31:0] ep);
      clr = c; stall = s; redirect = r; redirect_pc = rp; exc_req = x; eret = e; epc = ep;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_busy,
                            input logic e_flush, input logic e_adel);
      chk({tag, ".pc"},    pc,                 e_pc);
      chk({tag, ".pc4"},   pc4,                e_pc + 32'd4);
      chk({tag, ".busy"},  {31'd0, busy},      {31'd0, e_busy});
      chk({tag, ".flush"}, {31'd0, flush_fd},  {31'd0, e_flush});
      chk({tag, ".adel"},  {31'd0, adel_f},    {31'd0, e_adel});
      chk({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, !e_flush && !e_adel});
   endtask

   // Reference model: pc plus an optional parked target and a flush flag.
   logic [31:0] m_pc;
   logic [31:0] m_pend;
   logic        m_pend_v;
   logic        m_flush;

   function automatic logic bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h4FFC);
   endfunction

   task automatic model_step();
      if (clr) begin
         m_pc = 32'h3000; m_pend_v = 1'b0; m_flush = 1'b0;
      end else if (exc_req) begin
         m_pc = 32'h4180; m_pend_v = 1'b0; m_flush = 1'b1;
      end else if (eret) begin
         m_pc = epc; m_pend_v = 1'b0; m_flush = 1'b1;
      end else begin
         m_flush = 1'b0;
         if (redirect && stall) begin
            m_pend = redirect_pc; m_pend_v = 1'b1;
         end else if (redirect) begin
            m_pc = redirect_pc; m_pend_v = 1'b0;
         end else if (stall) begin
            // pc holds, any parked target stays parked
         end else if (m_pend_v) begin
            m_pc = m_pend; m_pend_v = 1'b0;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   function automatic logic [31:0] rand_pc();
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k == 0) return $urandom();
      if (k == 1) return 32'h4FFC;
      if (k == 2) return 32'hFFFF_FFF8;
      return 32'h3000 + 4 * $urandom_range(0, 2047);
   endfunction

   initial begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

      //        clr stl rd  rpc           exc eret epc          exp_pc        busy fl adel
      tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3000,     0, 0, 0)); // reset
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3004,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3008,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h300C,     0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 32'h3400,     0, 0, 32'h0,     32'h300C,     1, 0, 0)); // parked redirect
      tbl.push_back(mk(0, 1, 1, 32'h3400,     0, 0, 32'h0,     32'h300C,     1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3400,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3404,     0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 32'h3400,     0, 0, 32'h0,     32'h3404,     1, 0, 0)); // last writer wins
      tbl.push_back(mk(0, 1, 1, 32'h3500,     0, 0, 32'h0,     32'h3404,     1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3500,     0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 32'h3010,     0, 0, 32'h0,     32'h3010,     0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0,     32'h4180,     0, 1, 0)); // exc during stall
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h4184,     0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 32'h3002,     0, 0, 32'h0,     32'h3002,     0, 0, 1)); // misaligned
      tbl.push_back(mk(0, 0, 1, 32'h5000,     0, 0, 32'h0,     32'h5000,     0, 0, 1)); // above window
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h3020,  32'h3020,     0, 1, 0)); // eret
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3024,     0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 32'h3400,     0, 0, 32'h0,     32'h3024,     1, 0, 0)); // clr in HOLD
      tbl.push_back(mk(1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h3000,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3004,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3008,     0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 32'h3600,     0, 0, 32'h0,     32'h3008,     1, 0, 0)); // eret in HOLD
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h3100,  32'h3100,     0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h3104,     0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h3020,  32'h4180,     0, 1, 0)); // exc beats eret
      tbl.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h4180,     0, 0, 0)); // stall after flush
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h4184,     0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 32'h4FFC,     0, 0, 32'h0,     32'h4FFC,     0, 0, 0)); // top of window
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h5000,     0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,     32'h2FFC,     0, 0, 1)); // below window
      tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,    32'hFFFF_FFFC, 0, 0, 1)); // wrap
      tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,     32'h0000_0000, 0, 0, 1));
      tbl.push_back(mk(1, 0, 1, 32'h3400,     1, 1, 32'h3400,  32'h3000,     0, 0, 0)); // clr beats all

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].clr, tbl[i].stall, tbl[i].rd, tbl[i].rpc, tbl[i].exc, tbl[i].er, tbl[i].epc);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_busy, tbl[i].e_flush, tbl[i].e_adel);
      end

      // Randomized run against the reference model (starts from a reset).
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      model_step();
      @(posedge clk);
      #1;
      check_all("rnd_rst", m_pc, m_pend_v, m_flush, bad_addr(m_pc));
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 59) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 4) == 0,
               rand_pc(),
               $urandom_range(0, 24) == 0,
               $urandom_range(0, 16) == 0,
               rand_pc());
         model_step();
         @(posedge clk);
         #1;
         check_all($sformatf("rnd%0d", i), m_pc, m_pend_v, m_flush, bad_addr(m_pc));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: hazard unit holds F stage.
REQ-004 SHALL have ports redirect (input, 1) and redirect_pc (input, 32): branch/jump resolved in D.
REQ-005 SHALL have ports exc_req (input, 1) and eret (input, 1) and epc (input, 32): exception entry and return from CP0.
REQ-006 SHALL have ports pc (output, 32) and pc4 (output, 32): current fetch address and pc+4.
REQ-007 SHALL have ports fetch_valid (output, 1), flush_fd (output, 1), adel_f (output, 1): bubble marker, F/D flush, fetch address error.
REQ-008 SHALL have port busy (output, 1): high while a redirect is pending in HOLD.

Function
REQ-009 SHALL use states RUN, HOLD and FLUSH; RUN is the reset state.
REQ-010 SHALL apply next-pc priority clr > exc_req > eret > redirect > stall > sequential.
REQ-011 SHALL load pc = 32'h0000_4180 in the next cycle on exc_req, and enter FLUSH, regardless of stall.
REQ-012 SHALL load pc = epc in the next cycle on eret without exc_req, and enter FLUSH, regardless of stall.
REQ-013 In RUN with redirect and no stall, SHALL load pc = redirect_pc next cycle and stay in RUN.
REQ-014 In RUN with redirect and stall, SHALL latch redirect_pc into a pending register, hold pc, and enter HOLD.
REQ-015 In HOLD, SHALL hold pc while stall is 1; on the first cycle with stall = 0, SHALL load pc = pending value and return to RUN.
REQ-016 In HOLD, a new redirect SHALL overwrite the pending value; last writer wins.
REQ-017 exc_req or eret in HOLD SHALL discard the pending value; REQ-011 or REQ-012 then applies.
REQ-018 In FLUSH, SHALL drive fetch_valid = 0 and flush_fd = 1 for exactly one cycle, then continue by REQ-010 priority.
REQ-019 SHALL increment pc by 4 in RUN when no event and no stall occurs; wrap modulo 2^32, no saturation.
REQ-020 SHALL compute pc4 = pc + 32'd4 combinationally, unsigned 32-bit, wrapping.
REQ-021 SHALL assert adel_f combinationally when pc[1:0] != 0 or pc is outside 32'h3000..32'h4FFC inclusive.
REQ-022 SHALL drive fetch_valid = 0 whenever adel_f = 1; pc advances normally until CP0 raises exc_req.
REQ-023 SHALL drive busy = 1 exactly when state is HOLD.

Reset
REQ-024 On clr = 1 at a clock edge, SHALL set pc = 32'h0000_3000, state = RUN, pending = 0, regardless of other inputs.
REQ-025 After reset: pc4 = 32'h3004, fetch_valid = 1, flush_fd = 0, adel_f = 0, busy = 0.
REQ-026 clr asserted mid-HOLD or mid-FLUSH SHALL drop all pending state with no residual redirect.

Structure
REQ-027 SHALL take the constants RESET_PC (32'h3000), HANDLER_PC (32'h4180), IM_LO (32'h3000), IM_HI (32'h4FFC) and the state encoding from the shared CPU definitions package.
REQ-028 SHALL keep the address-check logic in one sub-module, fetch_addr_chk (pc in -> adel_f out); everything else stays flat.
REQ-029 SHALL contain one 32-bit pc register, one 32-bit pending register and a 2-bit state register only.

Verification
REQ-030 Reset then 3 free-running cycles -> pc = 3000, 3004, 3008, 300C; fetch_valid = 1 throughout.
REQ-031 redirect = 1 with redirect_pc = 3400 and stall = 1 for 2 cycles, then stall = 0 -> pc holds, busy = 1 for 2 cycles; next pc = 3400, busy = 0.
REQ-032 In HOLD, redirect to 3400 then to 3500 before stall drops -> pc = 3500.
REQ-033 exc_req during stall at pc = 3010 -> next pc = 4180, one cycle of flush_fd = 1 and fetch_valid = 0, then 4184.
REQ-034 redirect_pc = 3002, then redirect_pc = 5000 -> adel_f = 1 and fetch_valid = 0 at each; eret with epc = 3020 -> pc = 3020, adel_f = 0.
REQ-035 clr asserted in HOLD with pending = 3400 -> pc = 3000; after release with stall = 0, pc = 3004, never 3400.
